dmem_bank: RTL and testbench



---
 rtl/dmem_bank.sv | 198 +++++++++++++++++++
 tb/tb_dmem_bank.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_bank                                                    |
// | Description : Byte-addressed data memory with valid/ready request and      |
// |               response handshakes. Byte/half/word loads and stores with    |
// |               sign/zero extension and byte-lane write enables. Stores      |
// |               commit at the acceptance edge (1-cycle response), loads take |
// |               a registered array read (2-cycle response).                  |
// |               Optional macro DMEM_BANK_FAULT_EN enables fault detection    |
// |               (reserved size, misalignment, out-of-range address).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_bank #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_6000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_FAULT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_req_ready;
  logic                  w_rsp_valid;
  logic                  w_accept;
  logic                  w_mem_we;

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rd_word;

  logic [ADDR_WIDTH-1:0] w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [1:0]            w_size_eff;
  logic [1:0]            w_lane_eff;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_rep;
  logic                  w_fault;

  logic [1:0]            r_lane;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic                  r_ld_fault;

  logic [7:0]            w_ld_byte;
  logic [15:0]           w_ld_half;
  logic [31:0]           w_ld_ext;

  logic [31:0]           r_rdata;
  logic                  r_fault;

  // Offset from the bank base, modulo 2^ADDR_WIDTH
  assign w_off  = REQ_ADDR - ADDR_WIDTH'(BASE_ADDR);
  assign w_idx  = w_off[DEPTH_LOG2+1:2];
  assign w_lane = w_off[1:0];

  // Reserved size behaves as a word access; lanes are forced into alignment
  assign w_size_eff = (REQ_SIZE == 2'b11) ? 2'b10 : REQ_SIZE;

`ifdef DMEM_BANK_FAULT_EN
  assign w_fault = (REQ_SIZE == 2'b11)
                 | ((REQ_SIZE == 2'b01) & w_lane[0])
                 | ((REQ_SIZE == 2'b10) & (|w_lane))
                 | (REQ_ADDR < ADDR_WIDTH'(BASE_ADDR))
                 | (|w_off[ADDR_WIDTH-1:DEPTH_LOG2+2]);
`else
  // Upper offset bits are irrelevant when addresses wrap modulo the depth
  logic w_unused_off_hi;
  assign w_unused_off_hi = ^w_off[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign w_fault         = 1'b0;
`endif

  assign w_accept  = REQ_VALID & w_req_ready;
  assign w_mem_we  = w_accept & REQ_WE & ~w_fault;

  assign REQ_READY = w_req_ready;
  assign RSP_VALID = w_rsp_valid;
  assign RSP_RDATA = r_rdata;
  assign RSP_FAULT = r_fault;

  // Lane selection, byte enables and store data replication
  always_comb begin
    w_lane_eff  = 2'b00;
    w_be        = 4'b1111;
    w_wdata_rep = REQ_WDATA;
    case (w_size_eff)
      2'b00: begin
        w_lane_eff  = w_lane;
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{REQ_WDATA[7:0]}};
      end
      2'b01: begin
        w_lane_eff  = {w_lane[1], 1'b0};
        w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{REQ_WDATA[15:0]}};
      end
      default: begin
        w_lane_eff  = 2'b00;
        w_be        = 4'b1111;
        w_wdata_rep = REQ_WDATA;
      end
    endcase
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: w_req_ready = RST_N;
      S_RD:   w_state_nxt = S_RSP;
      S_RSP: begin
        w_rsp_valid = 1'b1;
        w_req_ready = RSP_READY;
        if (RSP_READY) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_req_ready && REQ_VALID) w_state_nxt = REQ_WE ? S_RSP : S_RD;
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Array: byte-lane writes at store acceptance, registered read at load acceptance
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (w_mem_we && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
    end
    if (w_accept && !REQ_WE) r_rd_word <= r_mem[w_idx];
  end

  // Load attributes captured at acceptance for use when the read data returns
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lane     <= 2'b00;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_ld_fault <= 1'b0;
    end else if (w_accept && !REQ_WE) begin
      r_lane     <= w_lane_eff;
      r_size     <= w_size_eff;
      r_uns      <= REQ_UNSIGNED;
      r_ld_fault <= w_fault;
    end
  end

  // Extract and extend the addressed byte/half from the registered word
  always_comb begin
    w_ld_byte = r_rd_word[{r_lane, 3'b000} +: 8];
    w_ld_half = r_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];
    case (r_size)
      2'b00:   w_ld_ext = {{24{~r_uns & w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_ext = {{16{~r_uns & w_ld_half[15]}}, w_ld_half};
      default: w_ld_ext = r_rd_word;
    endcase
  end

  // Response register: only written on the edge that raises RSP_VALID
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rdata <= 32'd0;
      r_fault <= 1'b0;
    end else if (w_accept && REQ_WE) begin
      r_rdata <= 32'd0;
      r_fault <= w_fault;
    end else if (r_state == S_RD) begin
      r_rdata <= r_ld_fault ? 32'd0 : w_ld_ext;
      r_fault <= r_ld_fault;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_bank                                                 |
// | Description : Scoreboard bench for dmem_bank. A byte-array reference model |
// |               produces expected responses at issue time; a monitor pops    |
// |               them at each response handshake and also checks latency and  |
// |               stability under backpressure. Honours DMEM_BANK_FAULT_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmem_bank;

  localparam int          AW     = 32;
  localparam int          DL     = 6;
  localparam int          NBYTES = 4 << DL;
  localparam logic [31:0] BASE   = 32'h0000_6000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WE = 1'b0;
  logic [1:0]  REQ_SIZE = 2'b00;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] REQ_ADDR = 32'd0;
  logic [31:0] REQ_WDATA = 32'd0;
  logic        RSP_READY = 1'b1;
  logic        REQ_READY;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_FAULT;

  dmem_bank #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RDATA(RSP_RDATA), .RSP_FAULT(RSP_FAULT)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic fault; logic [31:0] data; } exp_t;
  typedef struct { int t; logic we; } acc_t;

  exp_t       exp_q[$];
  acc_t       acc_q[$];
  logic [7:0] mem_b [NBYTES];
  int         checks = 0;
  int         failures = 0;
  int         bp_mode = 0;   // 0: ready high, 1: ready low, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: memory as a flat byte array indexed by offset from base
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic f, output logic [31:0] d);
    logic [31:0] off;
    logic [31:0] tmp;
    int nb;
    int start;
    off = a - BASE;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    f   = 1'b0;
    d   = 32'd0;
`ifdef DMEM_BANK_FAULT_EN
    if (sz == 2'd3 || (off % nb) != 0 || a < BASE || off >= NBYTES) f = 1'b1;
`endif
    if (f) return;
    start = int'(off % NBYTES);
    start = start - (start % nb);
    for (int k = 0; k < nb; k++) begin
      if (we) begin
        tmp = wd >> (8 * k);
        mem_b[start + k] = tmp[7:0];
      end else begin
        d = d | (32'(mem_b[start + k]) << (8 * k));
      end
    end
    if (!we && nb < 4 && !uns && d[8*nb-1]) d = d | ~((32'd1 << (8 * nb)) - 32'd1);
  endtask

  // Entered at posedge+1; returns at posedge+1 after the acceptance edge
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit has_exp, input logic [31:0] xd, input logic xf,
                       input int release_after, output int waited);
    exp_t e;
    logic f;
    logic [31:0] d;
    REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = uns; REQ_ADDR = a; REQ_WDATA = wd;
    REQ_VALID = 1'b1;
    if (release_after > 0) begin
      repeat (release_after) @(posedge CLK);
      #1 bp_mode = 0;
    end
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (!REQ_READY && waited < 100);
    if (!REQ_READY) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout: REQ_READY got 0, expected 1 within 100 cycles");
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      return;
    end
    model(we, sz, uns, a, wd, f, d);
    if (has_exp) begin
      d = xd;
      f = xf;
    end
    e.fault = f;
    e.data  = d;
    exp_q.push_back(e);
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: pending got %0d, expected 0", exp_q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  // Response-ready driver
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (bp_mode == 0)      RSP_READY = 1'b1;
      else if (bp_mode == 1) RSP_READY = 1'b0;
      else                   RSP_READY = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency, backpressure stability and scoreboard comparison
  initial begin
    int   ncyc;
    bit   fresh;
    bit   hold;
    logic [31:0] hd;
    logic hf;
    exp_t e;
    ncyc = 0; fresh = 1'b1; hold = 1'b0; hd = 32'd0; hf = 1'b0;
    forever begin
      @(negedge CLK);
      ncyc++;
      if (!RST_N) begin
        exp_q.delete();
        acc_q.delete();
        fresh = 1'b1;
        hold  = 1'b0;
        continue;
      end
      if (hold) begin
        check("hold_rsp_valid", 32'(RSP_VALID), 32'd1);
        check("hold_rsp_rdata", RSP_RDATA, hd);
        check("hold_rsp_fault", 32'(RSP_FAULT), 32'(hf));
      end
      hold = RSP_VALID && !RSP_READY;
      if (hold) begin
        hd = RSP_RDATA;
        hf = RSP_FAULT;
        check("hold_req_ready", 32'(REQ_READY), 32'd0);
      end
      if (RSP_VALID && fresh) begin
        fresh = 1'b0;
        if (acc_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL orphan_rsp: got response, expected none pending");
        end else begin
          check("latency", 32'(ncyc - acc_q[0].t), acc_q[0].we ? 32'd1 : 32'd2);
        end
      end
      if (RSP_VALID && RSP_READY) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp: got data %h, expected no response", RSP_RDATA);
        end else begin
          e = exp_q.pop_front();
          void'(acc_q.pop_front());
          check("rsp_rdata", RSP_RDATA, e.data);
          check("rsp_fault", 32'(RSP_FAULT), 32'(e.fault));
        end
        fresh = 1'b1;
      end
      if (REQ_VALID && REQ_READY) acc_q.push_back('{ncyc, REQ_WE});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    int w;
    logic [31:0] a;
    int r;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("reset_rsp_rdata", RSP_RDATA, 32'd0);
    check("reset_rsp_fault", 32'(RSP_FAULT), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("reset_req_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    #1;

    // Fill the whole array so every later load is defined
    for (int i = 0; i < NBYTES / 4; i++)
      issue(1'b1, 2'd2, 1'b0, BASE + 32'(4 * i), $urandom, 1'b0, 32'd0, 1'b0, 0, w);

    issue(1'b1, 2'd2, 1'b0, 32'h6000, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 0, w);
    issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 0, w);
    issue(1'b1, 2'd0, 1'b0, 32'h6003, 32'h80,       1'b1, 32'h0,        1'b0, 0, w);
    issue(1'b0, 2'd0, 1'b0, 32'h6003, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 0, w);
    issue(1'b0, 2'd0, 1'b1, 32'h6003, 32'h0,        1'b1, 32'h00000080, 1'b0, 0, w);
    issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0,        1'b1, 32'h80ADBEEF, 1'b0, 0, w);
    issue(1'b1, 2'd1, 1'b0, 32'h6006, 32'h8001,     1'b1, 32'h0,        1'b0, 0, w);
    issue(1'b0, 2'd1, 1'b0, 32'h6006, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 0, w);
    issue(1'b0, 2'd2, 1'b0, 32'h6004, 32'h0,        1'b0, 32'h0,        1'b0, 0, w);
`ifdef DMEM_BANK_FAULT_EN
    issue(1'b0, 2'd2, 1'b0, 32'h6002, 32'h0,        1'b1, 32'h0,        1'b1, 0, w);
    issue(1'b1, 2'd2, 1'b0, 32'h5FFC, 32'h11223344, 1'b1, 32'h0,        1'b1, 0, w);
    issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0,        1'b1, 32'h80ADBEEF, 1'b0, 0, w);
`endif

    // Backpressure: hold a load response, queue a store behind it
    drain();
    bp_mode = 1;
    issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0, 0, w);
    issue(1'b1, 2'd2, 1'b0, 32'h6010, 32'h12345678, 1'b0, 32'h0, 1'b0, 7, w);
    check("bp_release_same_edge", 32'(w), 32'd1);
    drain();

    // Randomised traffic with random response backpressure
    bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) a = BASE + 32'(NBYTES) + 32'($urandom_range(0, 63));
      else             a = BASE + 32'($urandom_range(0, NBYTES - 1));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'b0, 32'h0, 1'b0, 0, w);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end
    bp_mode = 0;
    drain();

    // Reset while the load is in RD
    issue(1'b1, 2'd2, 1'b0, 32'h6020, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 0, w);
    issue(1'b0, 2'd2, 1'b0, 32'h6020, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 0, w);
    RST_N = 1'b0;
    #1 check("rst_rd_rsp_valid", 32'(RSP_VALID), 32'd0);
    @(posedge CLK);
    #1;
    check("rst_rd_rsp_valid_after_edge", 32'(RSP_VALID), 32'd0);
    @(negedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("rst_rd_req_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    #1;
    issue(1'b0, 2'd2, 1'b0, 32'h6020, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 0, w);
    drain();

    // Reset while a response is held under backpressure
    bp_mode = 1;
    issue(1'b0, 2'd2, 1'b0, 32'h6020, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 0, w);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("rst_rsp_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_rsp_rdata", RSP_RDATA, 32'd0);
    bp_mode = 0;
    @(negedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("rst_rsp_req_ready", 32'(REQ_READY), 32'd1);
    @(posedge CLK);
    #1;
    issue(1'b0, 2'd0, 1'b1, 32'h6023, 32'h0, 1'b1, 32'h000000CA, 1'b0, 0, w);
    issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 1'b0, 32'h0, 1'b0, 0, w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
